mw_display_ctrl: RTL and testbench

//  Microwave cook-timer controller that sequences the 8-digit display driver.

---
 rtl/mw_defs_pkg.sv | 41 ++++
 rtl/mw_display_ctrl_bcd_time_counter.sv | 95 +++++++++
 rtl/mw_display_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mw_display_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_defs_pkg.sv
// Shared definitions for the microwave display controller: state codes,
// display word layout, time constants and a display-word packing helper.
// Pure declarations; no logic, no latency, no flow control.
package mw_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // mm:ss held as four BCD digits, most significant first
  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_time_t;

  // Display word layout {en, hex[3:0], dp}
  localparam int DW_EN     = 5;
  localparam int DW_HEX_HI = 4;
  localparam int DW_HEX_LO = 1;
  localparam int DW_DP     = 0;

  localparam int        QUICK_START_SECS = 30;
  localparam logic [3:0] QUICK_TENS      = 4'(QUICK_START_SECS / 10);
  localparam bcd_time_t QUICK_TIME       = {8'h00, QUICK_TENS, 4'(QUICK_START_SECS % 10)};
  localparam bcd_time_t MAX_TIME         = 16'h9959;

  function automatic logic [5:0] disp_word(input logic en, input logic [3:0] hex, input logic dp);
    logic [5:0] w;
    w                       = '0;
    w[DW_EN]                = en;
    w[DW_HEX_HI:DW_HEX_LO]  = hex;
    w[DW_DP]                = dp;
    return w;
  endfunction

endpackage

// File: rtl/mw_display_ctrl_bcd_time_counter.sv
// BCD mm:ss cook-time register with clear/load/+1 min/+10 s/+30 s/-1 s commands.
// One-cycle latency: a command is reflected in time_o after the next clock edge.
// No backpressure; adds saturate at 99:59 and a decrement at 00:00 is ignored.
module bcd_time_counter
  import mw_defs::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      clear_i,
  input  logic      load_i,
  input  bcd_time_t load_val_i,
  input  logic      add_min_i,
  input  logic      add_10s_i,
  input  logic      add_30s_i,
  input  logic      dec_i,
  output bcd_time_t time_o,
  output logic      zero_o
);

  bcd_time_t time_q, time_d;

  // +1 minute; at 99 minutes the whole time pins to 99:59
  function automatic bcd_time_t inc_min(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.mt == 4'd9 && t.mu == 4'd9) begin
      r = MAX_TIME;
    end else if (t.mu == 4'd9) begin
      r.mu = 4'd0;
      r.mt = t.mt + 4'd1;
    end else begin
      r.mu = t.mu + 4'd1;
    end
    return r;
  endfunction

  // add k tens-of-seconds, carrying into minutes past :59
  function automatic bcd_time_t add_tens(input bcd_time_t t, input logic [3:0] k);
    bcd_time_t  r;
    logic [3:0] s;
    r = t;
    s = t.st + k;
    if (s > 4'd5) begin
      r.st = s - 4'd6;
      r    = inc_min(r);
    end else begin
      r.st = s;
    end
    return r;
  endfunction

  // -1 second with BCD borrows; only used when the time is non-zero
  function automatic bcd_time_t dec_time(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.su != 4'd0) begin
      r.su = t.su - 4'd1;
    end else begin
      r.su = 4'd9;
      if (t.st != 4'd0) begin
        r.st = t.st - 4'd1;
      end else begin
        r.st = 4'd5;
        if (t.mu != 4'd0) begin
          r.mu = t.mu - 4'd1;
        end else begin
          r.mu = 4'd9;
          r.mt = t.mt - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign zero_o = (time_q == '0);
  assign time_o = time_q;

  // select the single command the controller issued this cycle
  always_comb begin
    time_d = time_q;
    if (clear_i)                 time_d = '0;
    else if (load_i)             time_d = load_val_i;
    else if (add_min_i)          time_d = inc_min(time_q);
    else if (add_10s_i)          time_d = add_tens(time_q, 4'd1);
    else if (add_30s_i)          time_d = add_tens(time_q, QUICK_TENS);
    else if (dec_i && !zero_o)   time_d = dec_time(time_q);
  end

  // time register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) time_q <= '0;
    else       time_q <= time_d;
  end

endmodule

// File: rtl/mw_display_ctrl.sv
// Microwave cook-timer FSM (IDLE/RUN/PAUSE/DONE), 1 s prescaler, done timer, display formatter.
// heating/done change on the edge that changes state; d1..d8 show the state/time one cycle later.
// No backpressure; one-cycle button pulses with fixed priority door > stop > start > add_min > add_sec.
// Optional blink of d1..d4 in PAUSE/DONE is built only when BLINK_EN is defined.
module mw_display_ctrl
  import mw_defs::*;
#(
  parameter int ONE_SEC_COUNT = 100_000_000,
  parameter int BLINK_COUNT   = 25_000_000,
  parameter int DONE_SECS     = 5
)(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       add_min,
  input  logic       add_sec,
  input  logic       door_open,
  output logic       heating,
  output logic       done,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8
);

  localparam int PW = (ONE_SEC_COUNT > 1) ? $clog2(ONE_SEC_COUNT) : 1;
  localparam int DW = (DONE_SECS > 1) ? $clog2(DONE_SECS) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(ONE_SEC_COUNT - 1);
  localparam logic [DW-1:0] DSEC_MAX = DW'(DONE_SECS - 1);

  if (ONE_SEC_COUNT < 1 || BLINK_COUNT < 1 || DONE_SECS < 1) begin : g_bad_param
    $error("mw_display_ctrl: counts must be at least 1");
  end

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [DW-1:0]   dsec_q, dsec_d;
  logic            heating_q, done_q;
  logic [5:0]      d1_q, d2_q, d3_q, d4_q, d8_q;
  logic            t_clear, t_load, t_min, t_10s, t_30s, t_dec, t_zero;
  bcd_time_t       t_now;
  logic            blink_on;

  bcd_time_counter u_time (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (t_clear),
    .load_i     (t_load),
    .load_val_i (QUICK_TIME),
    .add_min_i  (t_min),
    .add_10s_i  (t_10s),
    .add_30s_i  (t_30s),
    .dec_i      (t_dec),
    .time_o     (t_now),
    .zero_o     (t_zero)
  );

  // next state, prescaler/done-timer advance and time commands, in button priority order
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    dsec_d  = dsec_q;
    t_clear = 1'b0;
    t_load  = 1'b0;
    t_min   = 1'b0;
    t_10s   = 1'b0;
    t_30s   = 1'b0;
    t_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          t_clear = 1'b1;
        end else if (start) begin
          if (!door_open) begin
            t_load  = t_zero;
            state_d = ST_RUN;
            pre_d   = '0;
          end
        end else if (add_min) begin
          t_min = 1'b1;
        end else if (add_sec) begin
          t_10s = 1'b1;
        end
      end
      ST_RUN: begin
        if (door_open || stop) begin
          state_d = ST_PAUSE;
        end else if (t_zero) begin
          state_d = ST_DONE;
          pre_d   = '0;
          dsec_d  = '0;
        end else begin
          t_30s = start;
          // a tick coinciding with +30 s is deferred one cycle rather than lost
          if (pre_q == PRE_MAX) begin
            if (!start) begin
              pre_d = '0;
              t_dec = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          t_clear = 1'b1;
        end else if (start) begin
          if (!door_open && !t_zero) state_d = ST_RUN;
        end else if (add_min) begin
          t_min = 1'b1;
        end else if (add_sec) begin
          t_10s = 1'b1;
        end
      end
      ST_DONE: begin
        if (door_open || stop) begin
          state_d = ST_IDLE;
        end else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          if (dsec_q == DSEC_MAX) state_d = ST_IDLE;
          else                    dsec_d  = dsec_q + 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, counters and the heating/done outputs taken from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      dsec_q    <= '0;
      heating_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      dsec_q    <= dsec_d;
      heating_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

`ifdef BLINK_EN
  localparam int BW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_on_q;

  // digits blink in PAUSE/DONE, starting visible on entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (state_q == ST_PAUSE || state_q == ST_DONE) begin
      if (blink_cnt_q == BW'(BLINK_COUNT - 1)) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end
  end

  assign blink_on = blink_on_q;
`else
  assign blink_on = 1'b1;
`endif

  // display words: d1 = seconds units ... d4 = minute tens, colon on d3, state code on d8
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d1_q <= disp_word(1'b1, 4'd0, 1'b0);
      d2_q <= disp_word(1'b1, 4'd0, 1'b0);
      d3_q <= disp_word(1'b1, 4'd0, 1'b1);
      d4_q <= disp_word(1'b1, 4'd0, 1'b0);
      d8_q <= disp_word(1'b1, {2'b00, ST_IDLE}, 1'b0);
    end else begin
      d1_q <= disp_word(blink_on, t_now.su, 1'b0);
      d2_q <= disp_word(blink_on, t_now.st, 1'b0);
      d3_q <= disp_word(blink_on, t_now.mu, 1'b1);
      d4_q <= disp_word(blink_on, t_now.mt, 1'b0);
      d8_q <= disp_word(1'b1, {2'b00, state_q}, 1'b0);
    end
  end

  assign heating = heating_q;
  assign done    = done_q;
  assign d1      = d1_q;
  assign d2      = d2_q;
  assign d3      = d3_q;
  assign d4      = d4_q;
  assign d5      = 6'b0;
  assign d6      = 6'b0;
  assign d7      = 6'b0;
  assign d8      = d8_q;

endmodule

// File: tb/tb_mw_display_ctrl.sv
// Self-checking bench for mw_display_ctrl with short counts (1 s = 4 cycles, blink 2, done 2 s).
// Directed scenarios plus a randomized run against a seconds-based reference model.
module tb_mw_display_ctrl;

  localparam int ONE_SEC = 4;
  localparam int BLINK   = 2;
  localparam int DSECS   = 2;
  localparam logic [47:0] RESET_DISP = {6'b100000, 18'b0, 6'b100000, 6'b100001, 6'b100000, 6'b100000};
  localparam logic [5:0] W_IDLE = 6'b100000, W_RUN = 6'b100010, W_PAUSE = 6'b100100, W_DONE = 6'b100110;

  logic clock = 1'b0;
  logic reset, start, stop, add_min, add_sec, door_open;
  logic heating, done;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;

  int checks = 0;
  int errors = 0;

  // reference model: state code, time in whole seconds, cycles into current second,
  // cycles spent in DONE, consecutive cycles spent in PAUSE/DONE
  int m_state, m_secs, m_pre, m_dcyc, m_age;
  logic [5:0] exp_d1, exp_d2, exp_d3, exp_d4, exp_d8;

  mw_display_ctrl #(.ONE_SEC_COUNT(ONE_SEC), .BLINK_COUNT(BLINK), .DONE_SECS(DSECS)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .add_min(add_min),
    .add_sec(add_sec), .door_open(door_open), .heating(heating), .done(done),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
  );

  always #5 clock = ~clock;

  function automatic int sat(input int s);
    return (s > 5999) ? 5999 : s;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  // {d4,d3,d2,d1} for a time in seconds
  function automatic logic [23:0] words(input int s, input logic en);
    logic [15:0] b;
    b = to_bcd(s);
    return {en, b[15:12], 1'b0, en, b[11:8], 1'b1, en, b[7:4], 1'b0, en, b[3:0], 1'b0};
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_pre = 0; m_dcyc = 0; m_age = 0;
    {exp_d8, exp_d4, exp_d3, exp_d2, exp_d1} = {RESET_DISP[47:42], RESET_DISP[23:0]};
  endtask

  task automatic model_step();
    logic en;
`ifdef BLINK_EN
    en = ((m_age / BLINK) % 2) == 0;
    m_age = (m_state == 2 || m_state == 3) ? m_age + 1 : 0;
`else
    en = 1'b1;
`endif
    // display shows what held before this edge
    {exp_d4, exp_d3, exp_d2, exp_d1} = words(m_secs, en);
    exp_d8 = {1'b1, 4'(m_state), 1'b0};
    case (m_state)
      0: begin
        if (stop) m_secs = 0;
        else if (start) begin
          if (!door_open) begin
            if (m_secs == 0) m_secs = 30;
            m_state = 1; m_pre = 0;
          end
        end
        else if (add_min) m_secs = sat(m_secs + 60);
        else if (add_sec) m_secs = sat(m_secs + 10);
      end
      1: begin
        if (door_open || stop) m_state = 2;
        else if (m_secs == 0) begin m_state = 3; m_dcyc = 0; end
        else if (start) begin
          m_secs = sat(m_secs + 30);
          if (m_pre < ONE_SEC - 1) m_pre++;
        end
        else if (m_pre == ONE_SEC - 1) begin m_pre = 0; m_secs--; end
        else m_pre++;
      end
      2: begin
        if (stop) begin m_state = 0; m_secs = 0; end
        else if (start) begin if (!door_open && m_secs != 0) m_state = 1; end
        else if (add_min) m_secs = sat(m_secs + 60);
        else if (add_sec) m_secs = sat(m_secs + 10);
      end
      default: begin
        m_dcyc++;
        if (door_open || stop || m_dcyc == ONE_SEC * DSECS) m_state = 0;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    start = 1'b0; stop = 1'b0; add_min = 1'b0; add_sec = 1'b0;
  endtask

  function automatic logic [15:0] hex4();
    return {d4[4:1], d3[4:1], d2[4:1], d1[4:1]};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 0; stop = 0; add_min = 0; add_sec = 0; door_open = 0;
    model_reset();
    #1;
    checks++; if ({heating, done} !== 2'b00) begin errors++; $display("FAIL reset_hd got %b want 00", {heating, done}); end
    checks++; if ({d8, d7, d6, d5, d4, d3, d2, d1} !== RESET_DISP) begin errors++; $display("FAIL reset_disp got %h want %h", {d8, d7, d6, d5, d4, d3, d2, d1}, RESET_DISP); end
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    step();
    checks++; if ({d8, d7, d6, d5, d4, d3, d2, d1} !== RESET_DISP) begin errors++; $display("FAIL idle_hold got %h want %h", {d8, d7, d6, d5, d4, d3, d2, d1}, RESET_DISP); end
  endtask

  task automatic test_edit_and_run();
    repeat (2) begin add_min = 1'b1; step(); end
    repeat (3) begin add_sec = 1'b1; step(); end
    step();
    checks++; if (hex4() !== 16'h0230) begin errors++; $display("FAIL edit_0230 got %h want 0230", hex4()); end
    checks++; if ({d4, d3, d2, d1} !== {exp_d4, exp_d3, exp_d2, exp_d1}) begin errors++; $display("FAIL edit_model got %h want %h", {d4, d3, d2, d1}, {exp_d4, exp_d3, exp_d2, exp_d1}); end
    start = 1'b1; step();
    checks++; if (heating !== 1'b1) begin errors++; $display("FAIL run_heat got %b want 1", heating); end
    step();
    checks++; if (d8 !== W_RUN) begin errors++; $display("FAIL run_d8 got %b want %b", d8, W_RUN); end
    repeat (4) step();
    checks++; if (hex4() !== 16'h0229) begin errors++; $display("FAIL run_tick got %h want 0229", hex4()); end
    stop = 1'b1; step(); stop = 1'b1; step();
  endtask

  task automatic test_quick_start_done();
    int n;
    start = 1'b1; step();
    checks++; if (heating !== 1'b1) begin errors++; $display("FAIL quick_heat got %b want 1", heating); end
    step();
    checks++; if (hex4() !== 16'h0030) begin errors++; $display("FAIL quick_0030 got %h want 0030", hex4()); end
    n = 1;
    while (done !== 1'b1 && n < 300) begin step(); n++; end
    checks++; if (n != 121) begin errors++; $display("FAIL done_latency got %0d want 121", n); end
    checks++; if (heating !== 1'b0) begin errors++; $display("FAIL done_heat got %b want 0", heating); end
    step();
    checks++; if (d8 !== W_DONE) begin errors++; $display("FAIL done_d8 got %b want %b", d8, W_DONE); end
    repeat (6) step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b want 1", done); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_exit got %b want 0", done); end
    step();
    checks++; if ({d8, hex4()} !== {W_IDLE, 16'h0000}) begin errors++; $display("FAIL done_idle got %h want %h", {d8, hex4()}, {W_IDLE, 16'h0000}); end
  endtask

  task automatic test_door_pause();
    add_sec = 1'b1; step();
    start = 1'b1; step();
    repeat (22) step();
    door_open = 1'b1; step();
    checks++; if (heating !== 1'b0) begin errors++; $display("FAIL door_heat got %b want 0", heating); end
    step();
    checks++; if ({d8, hex4()} !== {W_PAUSE, 16'h0005}) begin errors++; $display("FAIL door_pause got %h want %h", {d8, hex4()}, {W_PAUSE, 16'h0005}); end
    start = 1'b1; step();
    checks++; if (heating !== 1'b0) begin errors++; $display("FAIL door_start got %b want 0", heating); end
    door_open = 1'b0; start = 1'b1; step();
    checks++; if (heating !== 1'b1) begin errors++; $display("FAIL resume_heat got %b want 1", heating); end
    repeat (2) step();
    checks++; if (hex4() !== 16'h0005) begin errors++; $display("FAIL resume_hold got %h want 0005", hex4()); end
    step();
    checks++; if (hex4() !== 16'h0004) begin errors++; $display("FAIL resume_tick got %h want 0004", hex4()); end
    stop = 1'b1; step(); stop = 1'b1; step();
  endtask

  task automatic test_saturate_borrow();
    repeat (99) begin add_min = 1'b1; step(); end
    repeat (5) begin add_sec = 1'b1; step(); end
    step();
    checks++; if (hex4() !== 16'h9950) begin errors++; $display("FAIL sat_9950 got %h want 9950", hex4()); end
    repeat (3) begin add_sec = 1'b1; step(); end
    add_min = 1'b1; step();
    step();
    checks++; if (hex4() !== 16'h9959) begin errors++; $display("FAIL sat_9959 got %h want 9959", hex4()); end
    start = 1'b1; step(); start = 1'b1; step();
    step();
    checks++; if (hex4() !== 16'h9959) begin errors++; $display("FAIL sat_plus30 got %h want 9959", hex4()); end
    stop = 1'b1; step(); stop = 1'b1; step();
    repeat (10) begin add_min = 1'b1; step(); end
    start = 1'b1; step();
    repeat (5) step();
    checks++; if (hex4() !== 16'h0959) begin errors++; $display("FAIL borrow_0959 got %h want 0959", hex4()); end
    stop = 1'b1; step(); stop = 1'b1; step();
    add_min = 1'b1; step();
    start = 1'b1; step();
    repeat (5) step();
    checks++; if (hex4() !== 16'h0059) begin errors++; $display("FAIL borrow_0059 got %h want 0059", hex4()); end
    stop = 1'b1; step(); stop = 1'b1; step();
  endtask

  task automatic test_stop_priority_reset();
    add_sec = 1'b1; step();
    start = 1'b1; step();
    repeat (2) step();
    stop = 1'b1; start = 1'b1; step();
    checks++; if (heating !== 1'b0) begin errors++; $display("FAIL stopwin_heat got %b want 0", heating); end
    step();
    checks++; if ({d8, hex4()} !== {W_PAUSE, 16'h0010}) begin errors++; $display("FAIL stopwin_disp got %h want %h", {d8, hex4()}, {W_PAUSE, 16'h0010}); end
    start = 1'b1; step();
    step();
    #2 reset = 1'b1;
    #1;
    checks++; if ({heating, done} !== 2'b00) begin errors++; $display("FAIL midrun_hd got %b want 00", {heating, done}); end
    checks++; if ({d8, d7, d6, d5, d4, d3, d2, d1} !== RESET_DISP) begin errors++; $display("FAIL midrun_disp got %h want %h", {d8, d7, d6, d5, d4, d3, d2, d1}, RESET_DISP); end
    model_reset();
    @(negedge clock); reset = 1'b0;
    step();
    checks++; if ({heating, done, d8, d4, d3, d2, d1} !== {1'b0, 1'b0, exp_d8, exp_d4, exp_d3, exp_d2, exp_d1}) begin errors++; $display("FAIL after_reset got %h want %h", {heating, done, d8, d4, d3, d2, d1}, {1'b0, 1'b0, exp_d8, exp_d4, exp_d3, exp_d2, exp_d1}); end
  endtask

  task automatic test_blink();
    add_sec = 1'b1; step();
    start = 1'b1; step();
    door_open = 1'b1; step();
    door_open = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if ({d4, d3, d2, d1} !== {exp_d4, exp_d3, exp_d2, exp_d1}) begin errors++; $display("FAIL blink_%0d got %h want %h", i, {d4, d3, d2, d1}, {exp_d4, exp_d3, exp_d2, exp_d1}); end
      checks++; if (d8 !== W_PAUSE) begin errors++; $display("FAIL blink_d8_%0d got %b want %b", i, d8, W_PAUSE); end
    end
    stop = 1'b1; step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 99) < 6);
      stop    = ($urandom_range(0, 99) < 2);
      add_min = ($urandom_range(0, 99) < 1);
      add_sec = ($urandom_range(0, 99) < 4);
      if (door_open) door_open = ($urandom_range(0, 4) != 0);
      else           door_open = ($urandom_range(0, 99) == 0);
      step();
      checks++; if ({heating, done} !== {m_state == 1, m_state == 3}) begin errors++; $display("FAIL rand_hd cyc %0d got %b want %b", i, {heating, done}, {m_state == 1, m_state == 3}); end
      checks++; if ({d8, d4, d3, d2, d1} !== {exp_d8, exp_d4, exp_d3, exp_d2, exp_d1}) begin errors++; $display("FAIL rand_disp cyc %0d got %h want %h", i, {d8, d4, d3, d2, d1}, {exp_d8, exp_d4, exp_d3, exp_d2, exp_d1}); end
    end
    door_open = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edit_and_run();
    test_quick_start_done();
    test_door_pause();
    test_saturate_borrow();
    test_stop_priority_reset();
    test_blink();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
